// File: rtl/lsu_axi_master.sv
// Load/store front end: one blocking byte/half/word access mapped onto AXI4-Lite.
// Optional macro LSU_MISALIGN_TRAP_EN: trap misaligned accesses instead of force-aligning them.
module lsu_axi_master (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] axi_araddr,
    output logic        axi_arvalid,
    input  logic        axi_arready,
    input  logic [31:0] axi_rdata,
    input  logic [1:0]  axi_rresp,
    input  logic        axi_rvalid,
    output logic        axi_rready,
    output logic [31:0] axi_awaddr,
    output logic        axi_awvalid,
    input  logic        axi_awready,
    output logic [31:0] axi_wdata,
    output logic [3:0]  axi_wstrb,
    output logic        axi_wvalid,
    input  logic        axi_wready,
    input  logic [1:0]  axi_bresp,
    input  logic        axi_bvalid,
    output logic        axi_bready
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] RD_ADDR = 3'd1;
    localparam logic [2:0] RD_DATA = 3'd2;
    localparam logic [2:0] WR_REQ  = 3'd3;
    localparam logic [2:0] WR_RESP = 3'd4;
    localparam logic [2:0] DONE    = 3'd5;

    // Byte offset actually used for the lanes; half/word offsets are forced aligned.
    function automatic logic [1:0] align_off(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'd0:    align_off = off;
            2'd1:    align_off = {off[1], 1'b0};
            default: align_off = 2'd0;
        endcase
    endfunction

    function automatic logic [3:0] lane_strb(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'd0:    lane_strb = 4'b0001 << off;
            2'd1:    lane_strb = 4'b0011 << off;
            default: lane_strb = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] rdata, input logic [1:0] size,
                                                input logic [1:0] off, input logic uns);
        logic [31:0] s;
        s = rdata >> {off, 3'b000};
        case (size)
            2'd0:    load_extend = uns ? {24'd0, s[7:0]}   : {{24{s[7]}}, s[7:0]};
            2'd1:    load_extend = uns ? {16'd0, s[15:0]}  : {{16{s[15]}}, s[15:0]};
            default: load_extend = s;
        endcase
    endfunction

`ifdef LSU_MISALIGN_TRAP_EN
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'd0:    misaligned = 1'b0;
            2'd1:    misaligned = off[0];
            default: misaligned = (off != 2'd0);
        endcase
    endfunction
`endif

    logic [2:0]  state_q, state_d;
    logic [1:0]  off_q, off_d;
    logic [1:0]  size_q, size_d;
    logic        unsigned_q, unsigned_d;
    logic [31:0] araddr_q, araddr_d;
    logic        arvalid_q, arvalid_d;
    logic        rready_q, rready_d;
    logic [31:0] awaddr_q, awaddr_d;
    logic        awvalid_q, awvalid_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        wvalid_q, wvalid_d;
    logic        bready_q, bready_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_err_q, resp_err_d;

    logic [1:0]  acc_off;
    logic        aw_done, w_done;
    logic        unused_resp_bits;

    assign acc_off          = align_off(req_size, req_addr[1:0]);
    assign aw_done          = !awvalid_q || axi_awready;
    assign w_done           = !wvalid_q || axi_wready;
    assign unused_resp_bits = axi_rresp[0] ^ axi_bresp[0];

    always_comb begin
        // NOTE: every _d gets a default first, so no path through the case can infer a latch.
        state_d      = state_q;
        off_d        = off_q;
        size_d       = size_q;
        unsigned_d   = unsigned_q;
        araddr_d     = araddr_q;
        arvalid_d    = arvalid_q;
        rready_d     = rready_q;
        awaddr_d     = awaddr_q;
        awvalid_d    = awvalid_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        wvalid_d     = wvalid_q;
        bready_d     = bready_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    off_d      = acc_off;
                    size_d     = req_size;
                    unsigned_d = req_unsigned;
`ifdef LSU_MISALIGN_TRAP_EN
                    if (misaligned(req_size, req_addr[1:0])) begin
                        state_d      = DONE;
                        resp_valid_d = 1'b1;
                        resp_rdata_d = 32'd0;
                        resp_err_d   = 1'b1;
                    end else
`endif
                    if (req_we) begin
                        state_d   = WR_REQ;
                        awaddr_d  = {req_addr[31:2], 2'b00};
                        awvalid_d = 1'b1;
                        wdata_d   = req_wdata << {acc_off, 3'b000};
                        wstrb_d   = lane_strb(req_size, acc_off);
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = RD_ADDR;
                        araddr_d  = {req_addr[31:2], 2'b00};
                        arvalid_d = 1'b1;
                    end
                end
            end
            RD_ADDR: begin
                if (axi_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RD_DATA;
                end
            end
            RD_DATA: begin
                if (axi_rvalid) begin
                    rready_d     = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = load_extend(axi_rdata, size_q, off_q, unsigned_q);
                    resp_err_d   = axi_rresp[1];
                    state_d      = DONE;
                end
            end
            WR_REQ: begin
                // Address and data channels retire independently; leave once both have.
                if (awvalid_q && axi_awready) awvalid_d = 1'b0;
                if (wvalid_q && axi_wready)   wvalid_d  = 1'b0;
                if (aw_done && w_done) begin
                    bready_d = 1'b1;
                    state_d  = WR_RESP;
                end
            end
            WR_RESP: begin
                if (axi_bvalid) begin
                    bready_d     = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = 32'd0;
                    resp_err_d   = axi_bresp[1];
                    state_d      = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= IDLE;
            off_q        <= 2'd0;
            size_q       <= 2'd0;
            unsigned_q   <= 1'b0;
            araddr_q     <= 32'd0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            awaddr_q     <= 32'd0;
            awvalid_q    <= 1'b0;
            wdata_q      <= 32'd0;
            wstrb_q      <= 4'd0;
            wvalid_q     <= 1'b0;
            bready_q     <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'd0;
            resp_err_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q      <= state_d;
            off_q        <= off_d;
            size_q       <= size_d;
            unsigned_q   <= unsigned_d;
            araddr_q     <= araddr_d;
            arvalid_q    <= arvalid_d;
            rready_q     <= rready_d;
            awaddr_q     <= awaddr_d;
            awvalid_q    <= awvalid_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            wvalid_q     <= wvalid_d;
            bready_q     <= bready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign req_ready   = (state_q == IDLE);
    assign resp_valid  = resp_valid_q;
    assign resp_rdata  = resp_rdata_q;
    assign resp_err    = resp_err_q;
    assign axi_araddr  = araddr_q;
    assign axi_arvalid = arvalid_q;
    assign axi_rready  = rready_q;
    assign axi_awaddr  = awaddr_q;
    assign axi_awvalid = awvalid_q;
    assign axi_wdata   = wdata_q;
    assign axi_wstrb   = wstrb_q;
    assign axi_wvalid  = wvalid_q;
    assign axi_bready  = bready_q;

endmodule

// File: tb/tb_lsu_axi_master.sv
// Self-checking bench for lsu_axi_master: directed table, randomized accesses against a
// behavioural model, reset abort and stray-response sequences. Honours LSU_MISALIGN_TRAP_EN.
module tb_lsu_axi_master;

    logic        clk, rstn;
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_size;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic [31:0] axi_araddr, axi_rdata, axi_awaddr, axi_wdata;
    logic        axi_arvalid, axi_arready, axi_rvalid, axi_rready;
    logic        axi_awvalid, axi_awready, axi_wvalid, axi_wready, axi_bvalid, axi_bready;
    logic [1:0]  axi_rresp, axi_bresp;
    logic [3:0]  axi_wstrb;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] rdata;
        logic [1:0]  resp;
        int          wa;      // ar/aw ready wait
        int          ww;      // w ready wait
        int          wrb;     // r/b valid wait
        bit          trap;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic [3:0]  e_strb;
        logic [31:0] e_rdata;
        logic        e_err;
    } vec_t;

    lsu_axi_master dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .req_unsigned(req_unsigned),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .axi_araddr(axi_araddr), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
        .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rvalid(axi_rvalid),
        .axi_rready(axi_rready),
        .axi_awaddr(axi_awaddr), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
        .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wvalid(axi_wvalid),
        .axi_wready(axi_wready),
        .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_slave();
        axi_arready = 1'b0; axi_rvalid = 1'b0; axi_rdata = 32'd0; axi_rresp = 2'd0;
        axi_awready = 1'b0; axi_wready = 1'b0; axi_bvalid = 1'b0; axi_bresp = 2'd0;
    endtask

    function automatic vec_t mkv(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [1:0] size, input logic uns, input logic [31:0] rdata,
                                 input logic [1:0] resp, input int wa, input int ww, input int wrb,
                                 input bit trap, input logic [31:0] e_addr, input logic [31:0] e_wdata,
                                 input logic [3:0] e_strb, input logic [31:0] e_rdata, input logic e_err);
        vec_t v;
        v.we = we; v.addr = addr; v.wdata = wdata; v.size = size; v.uns = uns;
        v.rdata = rdata; v.resp = resp; v.wa = wa; v.ww = ww; v.wrb = wrb; v.trap = trap;
        v.e_addr = e_addr; v.e_wdata = e_wdata; v.e_strb = e_strb;
        v.e_rdata = e_rdata; v.e_err = e_err;
        return v;
    endfunction

    // Reference model: derive the expected bus payload and response from the access rules.
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        int off, sz, bits;
        logic [31:0] s, val;
        off = int'(v.addr[1:0]);
        sz  = (v.size == 2'd3) ? 2 : int'(v.size);
        r.trap   = 1'b0;
        r.e_addr = v.addr & 32'hFFFF_FFFC;
`ifdef LSU_MISALIGN_TRAP_EN
        if ((sz == 1 && off % 2 == 1) || (sz == 2 && off != 0)) begin
            r.trap = 1'b1; r.e_rdata = 32'd0; r.e_err = 1'b1; r.e_wdata = 32'd0; r.e_strb = 4'd0;
            return r;
        end
`endif
        if (sz == 1) off = off - off % 2;
        else if (sz == 2) off = 0;
        bits = 8 << sz;
        r.e_strb  = 4'(((1 << (bits / 8)) - 1) << off);
        r.e_wdata = v.wdata << (8 * off);
        r.e_err   = (v.resp >= 2'd2);
        if (v.we) begin
            r.e_rdata = 32'd0;
        end else begin
            s = v.rdata >> (8 * off);
            if (bits == 32) begin
                val = s;
            end else begin
                val = s & ((32'd1 << bits) - 32'd1);
                if (!v.uns && val >= (32'd1 << (bits - 1))) val = val - (32'd1 << bits);
            end
            r.e_rdata = val;
        end
        return r;
    endfunction

    task automatic do_reset();
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    // Issue one request at a negedge with the DUT idle, act as the slave, then check everything.
    task automatic run_txn(input vec_t v, input string tag);
        int cyc = 1, resp_cyc = -1, exp_resp, wmax;
        int first_ar = -1, last_ar = -1, first_aw = -1, last_aw = -1, last_w = -1;
        int first_r = -1, first_b = -1;
        int ar_cnt = 0, aw_cnt = 0, w_cnt = 0, r_cnt = 0, b_cnt = 0, stable_bad = 0;
        logic [31:0] got_addr = 32'd0, got_wdata = 32'd0, got_rdata = 32'd0;
        logic [31:0] prev_ar = 32'd0, prev_aw = 32'd0, prev_w = 32'd0;
        logic [3:0]  got_strb = 4'd0, prev_s = 4'd0;
        logic        got_err = 1'b0, ar_pend = 1'b0, aw_pend = 1'b0, w_pend = 1'b0;

        req_we = v.we; req_addr = v.addr; req_wdata = v.wdata;
        req_size = v.size; req_unsigned = v.uns; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        req_we = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
        req_size = 2'($urandom); req_unsigned = 1'($urandom);
        check({tag, ":busy_ready"}, req_ready, 0);

        while (resp_cyc < 0 && cyc <= 60) begin
            if (resp_valid) begin
                resp_cyc = cyc; got_rdata = resp_rdata; got_err = resp_err;
            end else begin
                if (ar_pend && (!axi_arvalid || axi_araddr !== prev_ar)) stable_bad++;
                if (aw_pend && (!axi_awvalid || axi_awaddr !== prev_aw)) stable_bad++;
                if (w_pend && (!axi_wvalid || axi_wdata !== prev_w || axi_wstrb !== prev_s)) stable_bad++;
                if (axi_arvalid) begin
                    if (first_ar < 0) begin first_ar = cyc; got_addr = axi_araddr; end
                    last_ar = cyc; axi_arready = (ar_cnt >= v.wa); ar_cnt++;
                end else axi_arready = 1'b0;
                if (axi_awvalid) begin
                    if (first_aw < 0) begin first_aw = cyc; got_addr = axi_awaddr; end
                    last_aw = cyc; axi_awready = (aw_cnt >= v.wa); aw_cnt++;
                end else axi_awready = 1'b0;
                if (axi_wvalid) begin
                    if (w_cnt == 0) begin got_wdata = axi_wdata; got_strb = axi_wstrb; end
                    last_w = cyc; axi_wready = (w_cnt >= v.ww); w_cnt++;
                end else axi_wready = 1'b0;
                ar_pend = axi_arvalid && !axi_arready; prev_ar = axi_araddr;
                aw_pend = axi_awvalid && !axi_awready; prev_aw = axi_awaddr;
                w_pend  = axi_wvalid && !axi_wready;   prev_w = axi_wdata; prev_s = axi_wstrb;
                if (axi_rready) begin
                    if (first_r < 0) first_r = cyc;
                    axi_rvalid = (r_cnt >= v.wrb); r_cnt++;
                end else axi_rvalid = 1'b0;
                if (axi_bready) begin
                    if (first_b < 0) first_b = cyc;
                    axi_bvalid = (b_cnt >= v.wrb); b_cnt++;
                end else axi_bvalid = 1'b0;
                axi_rdata = v.rdata; axi_rresp = v.resp; axi_bresp = v.resp;
                @(negedge clk);
                cyc++;
            end
        end
        idle_slave();

        wmax = (v.wa > v.ww) ? v.wa : v.ww;
        exp_resp = v.trap ? 1 : (3 + (v.we ? wmax : v.wa) + v.wrb);
        if (v.trap) begin
            check({tag, ":no_ar"}, first_ar, -1);
            check({tag, ":no_aw"}, first_aw, -1);
        end else if (v.we) begin
            check({tag, ":aw_first"}, first_aw, 1);
            check({tag, ":aw_last"}, last_aw, 1 + v.wa);
            check({tag, ":w_last"}, last_w, 1 + v.ww);
            check({tag, ":b_first"}, first_b, 2 + wmax);
            check({tag, ":no_ar"}, first_ar, -1);
            check({tag, ":awaddr"}, got_addr, v.e_addr);
            check({tag, ":wdata"}, got_wdata, v.e_wdata);
            check({tag, ":wstrb"}, got_strb, v.e_strb);
        end else begin
            check({tag, ":ar_first"}, first_ar, 1);
            check({tag, ":ar_last"}, last_ar, 1 + v.wa);
            check({tag, ":r_first"}, first_r, 2 + v.wa);
            check({tag, ":no_aw"}, first_aw, -1);
            check({tag, ":araddr"}, got_addr, v.e_addr);
        end
        check({tag, ":valid_stable"}, stable_bad, 0);
        check({tag, ":resp_cycle"}, resp_cyc, exp_resp);
        check({tag, ":resp_rdata"}, got_rdata, v.e_rdata);
        check({tag, ":resp_err"}, got_err, v.e_err);

        @(negedge clk);
        check({tag, ":resp_pulse"}, resp_valid, 0);
        check({tag, ":ready_after"}, req_ready, 1);
        check({tag, ":rdata_hold"}, resp_rdata, v.e_rdata);
        if (resp_cyc < 0) do_reset();
    endtask

    vec_t tbl[10];

    initial begin
        int seen;
        vec_t v;

        tbl[0] = mkv(0, 32'h100, 32'h0, 2, 0, 32'hDEADBEEF, 0, 0, 0, 0,
                     0, 32'h100, 32'h0, 4'h0, 32'hDEADBEEF, 0);
        tbl[1] = mkv(0, 32'h103, 32'h0, 0, 0, 32'h80000000, 0, 0, 0, 0,
                     0, 32'h100, 32'h0, 4'h0, 32'hFFFFFF80, 0);
        tbl[2] = mkv(0, 32'h103, 32'h0, 0, 1, 32'h80000000, 0, 0, 0, 0,
                     0, 32'h100, 32'h0, 4'h0, 32'h00000080, 0);
        tbl[3] = mkv(1, 32'h206, 32'h1234, 1, 0, 32'h0, 0, 0, 0, 0,
                     0, 32'h204, 32'h12340000, 4'b1100, 32'h0, 0);
        tbl[4] = mkv(1, 32'h300, 32'hCAFEF00D, 2, 0, 32'h0, 0, 0, 3, 0,
                     0, 32'h300, 32'hCAFEF00D, 4'b1111, 32'h0, 0);
        tbl[5] = mkv(0, 32'h10, 32'h0, 2, 0, 32'h11223344, 2'b10, 0, 0, 0,
                     0, 32'h10, 32'h0, 4'h0, 32'h11223344, 1);
`ifdef LSU_MISALIGN_TRAP_EN
        tbl[6] = mkv(0, 32'h102, 32'h0, 2, 0, 32'hAABBCCDD, 0, 0, 0, 0,
                     1, 32'h100, 32'h0, 4'h0, 32'h0, 1);
`else
        tbl[6] = mkv(0, 32'h102, 32'h0, 2, 0, 32'hAABBCCDD, 0, 0, 0, 0,
                     0, 32'h100, 32'h0, 4'h0, 32'hAABBCCDD, 0);
`endif
        tbl[7] = mkv(1, 32'h1, 32'hAB, 0, 0, 32'h0, 2'b11, 0, 0, 1,
                     0, 32'h0, 32'h0000AB00, 4'b0010, 32'h0, 1);
        tbl[8] = mkv(0, 32'h2, 32'h0, 1, 0, 32'h80010000, 0, 2, 0, 1,
                     0, 32'h0, 32'h0, 4'h0, 32'hFFFF8001, 0);
        tbl[9] = mkv(1, 32'h20, 32'h01020304, 3, 0, 32'h0, 0, 3, 0, 2,
                     0, 32'h20, 32'h01020304, 4'b1111, 32'h0, 0);

        rstn = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
        req_size = 2'd0; req_unsigned = 1'b0;
        idle_slave();

        // Reset values, during and just after reset.
        @(negedge clk);
        check("rst:req_ready", req_ready, 1);
        check("rst:valids", {axi_arvalid, axi_awvalid, axi_wvalid, resp_valid}, 0);
        check("rst:readies", {axi_rready, axi_bready}, 0);
        check("rst:addrs", axi_araddr | axi_awaddr, 0);
        check("rst:wdata", axi_wdata, 0);
        check("rst:wstrb", axi_wstrb, 0);
        check("rst:resp", {resp_err, resp_rdata}, 0);
        rstn = 1'b1;
        @(negedge clk);
        check("post_rst:req_ready", req_ready, 1);

        for (int i = 0; i < 10; i++) run_txn(tbl[i], $sformatf("tbl%0d", i));

        // Abort a load in RD_DATA by reset: no response, outputs back to reset values.
        req_we = 1'b0; req_addr = 32'h40; req_size = 2'd2; req_unsigned = 1'b0; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        check("abort:arvalid_c1", axi_arvalid, 1);
        axi_arready = 1'b1;
        @(negedge clk);
        axi_arready = 1'b0;
        check("abort:rready_c2", axi_rready, 1);
        rstn = 1'b0;
        #1;
        check("abort:arvalid", axi_arvalid, 0);
        check("abort:rready", axi_rready, 0);
        check("abort:req_ready", req_ready, 1);
        check("abort:resp_valid", resp_valid, 0);
        check("abort:araddr", axi_araddr, 0);
        @(negedge clk);
        rstn = 1'b1;

        // Stray rvalid/bvalid while idle must be ignored.
        axi_rvalid = 1'b1; axi_bvalid = 1'b1; axi_rdata = 32'h12345678; axi_bresp = 2'b10;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (resp_valid || axi_rready || axi_bready || !req_ready) seen++;
        end
        check("stray:ignored", seen, 0);
        check("stray:rdata_reset", resp_rdata, 0);
        idle_slave();

        // Randomized accesses against the model.
        for (int i = 0; i < 40; i++) begin
            v.we = 1'($urandom); v.addr = $urandom; v.wdata = $urandom;
            v.size = 2'($urandom); v.uns = 1'($urandom); v.rdata = $urandom;
            v.resp = 2'($urandom);
            v.wa = int'($urandom_range(0, 3)); v.ww = int'($urandom_range(0, 3));
            v.wrb = int'($urandom_range(0, 3));
            v = model(v);
            run_txn(v, $sformatf("rnd%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/lsu_axi_master.md
# lsu_axi_master

Load/store front end between the core's memory pipeline stage and the MMU's core-side AXI4-Lite slave port. It accepts one byte, halfword or word request at a time from the core, lane-aligns write data and strobes, runs a single AXI4-Lite read or write transaction, then returns extracted and extended load data or a write completion. It is strictly blocking, with one outstanding transaction.

## Interface
Parameters: none.

Ports:
- clk  in  1  system clock
- rstn  in  1  reset, asynchronous, active-low
- req_valid  in  1  core request valid
- req_ready  out  1  block idle, request accepted when req_valid && req_ready
- req_we  in  1  1 = store, 0 = load
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- req_size  in  2  0 = byte, 1 = half, 2 = word (3 is treated as word)
- req_unsigned  in  1  loads: 1 = zero-extend, 0 = sign-extend
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data (0 for stores)
- resp_err  out  1  bus error or misalignment trap
- axi_araddr  out  32, axi_arvalid  out  1, axi_arready  in  1
- axi_rdata  in  32, axi_rresp  in  2, axi_rvalid  in  1, axi_rready  out  1
- axi_awaddr  out  32, axi_awvalid  out  1, axi_awready  in  1
- axi_wdata  out  32, axi_wstrb  out  4, axi_wvalid  out  1, axi_wready  in  1
- axi_bresp  in  2, axi_bvalid  in  1, axi_bready  out  1

## Operation
- States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE.
- req_ready = (state == IDLE).
- The accept cycle latches we, addr, size, unsigned and wdata.
  - Load goes to RD_ADDR.
  - Store goes to WR_REQ.
- Bus addresses: axi_araddr / axi_awaddr = {addr[31:2], 2'b00}. Let off = addr[1:0].
- Strobes:
  - byte: 4'b0001 << off
  - half: 4'b0011 << off
  - word: 4'b1111
- axi_wdata = req_wdata << (8*off).
- Load extraction:
  - s = rdata >> (8*off).
  - byte uses s[7:0], half uses s[15:0], word uses s.
  - Extend per req_unsigned.
- RD_ADDR: arvalid = 1 until arready, then RD_DATA.
- RD_DATA: rready = 1. On rvalid, capture the extended data and err = rresp[1], then go to DONE.
- WR_REQ: awvalid and wvalid are both raised. Each drops independently after its own handshake. When both handshakes are done, go to WR_RESP. Simultaneous handshakes in one cycle go to WR_RESP on the next cycle.
- WR_RESP: bready = 1. On bvalid, err = bresp[1], then go to DONE.
- DONE: resp_valid = 1 for one cycle, then IDLE.
  - resp_rdata and resp_err hold until the next DONE.
- AXI valids, once raised, stay stable with stable payload until their handshake completes.

## Timing
- Reset state is IDLE.
- Reset values:
  - req_ready = 1.
  - All axi_*valid, axi_rready, axi_bready = 0.
  - axi_araddr, axi_awaddr, axi_wdata = 0; axi_wstrb = 0.
  - resp_valid = 0, resp_rdata = 0, resp_err = 0.
- Minimum latency with a zero-wait slave, accept at cycle 0:
  - Read: arvalid at cycle 1, rready at cycle 2, resp_valid at cycle 3.
  - Write: aw/w at cycle 1, bready at cycle 2, resp_valid at cycle 3.
- Registered outputs: all outputs are registered except req_ready.
- rvalid / bvalid outside RD_DATA / WR_RESP are ignored (not acknowledged).
- rstn asserted mid-transaction: immediate return to IDLE with all outputs at reset values. The aborted transaction produces no response.
- req_valid while busy: ignored; the core must hold it until req_ready.

## Configuration
- LSU_MISALIGN_TRAP_EN defined:
  - A misaligned request (half with addr[0]=1, or word with addr[1:0]≠0) issues no bus transaction.
  - The block goes IDLE → DONE, so resp_valid is asserted 1 cycle after accept, with resp_err = 1 and resp_rdata = 0.
- Undefined:
  - Misaligned requests are force-aligned: half uses off = {addr[1], 0}, word uses off = 0.
  - They then proceed as normal transactions with no error.

## Test plan
- Word load at 0x100, slave returns 0xDEADBEEF with zero wait → araddr 0x100, resp_valid at cycle 3, resp_rdata 0xDEADBEEF, err 0.
- Signed byte load at 0x103, rdata 0x80000000 → resp_rdata 0xFFFFFF80. Same access unsigned → 0x00000080.
- Half store of 0x1234 at 0x206 → awaddr 0x204, wdata 0x12340000, wstrb 4'b1100; resp_valid after bvalid.
- Write where awready comes at cycle 1 and wready only at cycle 4 → awvalid drops after cycle 1, wvalid held through 4, bready from cycle 5.
- Load with rresp = 2'b10 → resp_err 1. rstn pulsed while in RD_DATA → arvalid/rready 0, no resp_valid, req_ready 1.
- Word load at 0x102: with LSU_MISALIGN_TRAP_EN → no arvalid, resp_valid at cycle 1 with err 1. Without it → araddr 0x100, normal response.
